// File: rtl/pwm_gen_pkg.sv
// pwm_gen_pkg: timer mode/state encodings and the PWM compare function.
package pwm_gen_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    RUN   = 2'b10
  } state_e;
  localparam logic [1:0] MODE_LEFT  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_UNAL  = 2'b10;
  // Any functions value with bit 1 set selects unaligned mode.
  function automatic logic pwm_cmp(
    input logic [15:0] cnt,
    input logic [15:0] c1,
    input logic [15:0] c2,
    input logic [1:0]  f
  );
    return f[1] ? (cnt >= c1 && cnt < c2) : (f == MODE_RIGHT) ? (cnt >= c1) : (cnt < c1);
  endfunction
endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: shadowed single-channel PWM generator locked to an external timebase.
module pwm_gen
  import pwm_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_en,
  input  logic [15:0] count_val,
  input  logic [15:0] compare1,
  input  logic [15:0] compare2,
  input  logic [1:0]  functions,
  output logic        pwm_out,
  output logic        cycle_pulse,
  output logic [1:0]  state_o
);
  state_e      state_q, state_d;
  logic [15:0] count_val_q, cmp1_sh_q, cmp1_sh_d, cmp2_sh_q, cmp2_sh_d;
  logic [1:0]  func_sh_q, func_sh_d;
  logic        pwm_out_q, cycle_pulse_q, wrap, load;
  assign wrap = (count_val == '0) && (count_val_q != '0);
  always_comb begin
    state_d = !pwm_en ? IDLE :
              (state_q == IDLE)  ? ARMED :
              (state_q == ARMED) ? ((count_val == '0) ? RUN : ARMED) :
              (state_q == RUN)   ? RUN : IDLE;
    // Shadows follow the registers in IDLE, then only reload at period start.
    load = (state_q == IDLE) || ((state_d == RUN) && ((state_q == ARMED) || wrap));
    cmp1_sh_d = load ? compare1  : cmp1_sh_q;
    cmp2_sh_d = load ? compare2  : cmp2_sh_q;
    func_sh_d = load ? functions : func_sh_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_val_q   <= '0;
      cmp1_sh_q     <= '0;
      cmp2_sh_q     <= '0;
      func_sh_q     <= '0;
      pwm_out_q     <= 1'b0;
      cycle_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_val_q   <= count_val;
      cmp1_sh_q     <= cmp1_sh_d;
      cmp2_sh_q     <= cmp2_sh_d;
      func_sh_q     <= func_sh_d;
      pwm_out_q     <= (state_d == RUN) && pwm_cmp(count_val, cmp1_sh_d, cmp2_sh_d, func_sh_d);
      cycle_pulse_q <= (state_q == RUN) && (state_d == RUN) && wrap;
    end
  end
  assign pwm_out     = pwm_out_q;
  assign cycle_pulse = cycle_pulse_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed self-checking bench for pwm_gen.
module tb_pwm_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_en = 1'b0;
  logic [15:0] count_val = '0;
  logic [15:0] compare1 = '0;
  logic [15:0] compare2 = '0;
  logic [1:0]  functions = '0;
  logic        pwm_out, cycle_pulse;
  logic [1:0]  state_o;
  int checks = 0;
  int errors = 0;

  pwm_gen dut (
    .clk(clk), .rst(rst), .pwm_en(pwm_en), .count_val(count_val),
    .compare1(compare1), .compare2(compare2), .functions(functions),
    .pwm_out(pwm_out), .cycle_pulse(cycle_pulse), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [15:0] c);
    count_val = c;
    @(posedge clk);
    #1;
  endtask

  // Counts 1..7 of a period; m[c] is the expected pwm_out for count c.
  task automatic period(input logic [7:0] m);
    for (int c = 1; c < 8; c++) begin
      tick(16'(c));
      chk("period_pwm", 16'(pwm_out), 16'(m[c]));
      chk("period_pulse", 16'(cycle_pulse), 16'(0));
    end
  endtask

  task automatic wrap_chk(input logic p);
    tick(16'd0);
    chk("wrap_pulse", 16'(cycle_pulse), 16'(1));
    chk("wrap_pwm", 16'(pwm_out), 16'(p));
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst_state", 16'(state_o), 16'(0));
    chk("rst_pwm", 16'(pwm_out), 16'(0));
    chk("rst_pulse", 16'(cycle_pulse), 16'(0));
    rst = 1'b0;
    functions = 2'b00; compare1 = 16'd3; pwm_en = 1'b1;
    tick(16'd5);
    chk("armed_state", 16'(state_o), 16'(1));
    chk("armed_pwm", 16'(pwm_out), 16'(0));
    tick(16'd6);
    tick(16'd7);
    chk("armed_hold", 16'(state_o), 16'(1));
    tick(16'd0);
    chk("run_state", 16'(state_o), 16'(2));
    chk("run_pwm0", 16'(pwm_out), 16'(1));
    chk("run_pulse0", 16'(cycle_pulse), 16'(0));
    period(8'b0000_0110);
    wrap_chk(1'b1);
    // compare1 write mid-period must wait for the wrap
    tick(16'd1); chk("mid_pwm1", 16'(pwm_out), 16'(1));
    tick(16'd2); chk("mid_pwm2", 16'(pwm_out), 16'(1));
    tick(16'd3); chk("mid_pwm3", 16'(pwm_out), 16'(0));
    compare1 = 16'd6;
    tick(16'd4); chk("mid_pwm4", 16'(pwm_out), 16'(0));
    tick(16'd5); chk("mid_pwm5", 16'(pwm_out), 16'(0));
    tick(16'd6); chk("mid_pwm6", 16'(pwm_out), 16'(0));
    tick(16'd7); chk("mid_pwm7", 16'(pwm_out), 16'(0));
    wrap_chk(1'b1);
    period(8'b0011_1110);
    functions = 2'b01; compare1 = 16'd0;
    wrap_chk(1'b1);
    period(8'b1111_1110);
    functions = 2'b00;
    wrap_chk(1'b0);
    period(8'b0000_0000);
    functions = 2'b10; compare1 = 16'd2; compare2 = 16'd5;
    wrap_chk(1'b0);
    period(8'b0001_1100);
    compare2 = 16'd1;
    wrap_chk(1'b0);
    period(8'b0000_0000);
    functions = 2'b00; compare1 = 16'hFFFF;
    wrap_chk(1'b1);
    tick(16'hFFFE); chk("max_fffe", 16'(pwm_out), 16'(1));
    tick(16'hFFFF); chk("max_ffff", 16'(pwm_out), 16'(0));
    wrap_chk(1'b1);
    compare1 = 16'd0;
    for (int k = 0; k < 4; k++) begin
      tick(16'd0);
      chk("zero_pwm", 16'(pwm_out), 16'(1));
      chk("zero_pulse", 16'(cycle_pulse), 16'(0));
    end
    compare1 = 16'd2;
    for (int p = 0; p < 2; p++) begin
      for (int v = 1; v < 4; v++) begin
        for (int k = 0; k < 4; k++) begin
          tick(16'(v % 3));
          chk("pre_pulse", 16'(cycle_pulse), 16'((v == 3) && (k == 0)));
          chk("pre_pwm", 16'(pwm_out), 16'((p == 0) ? 1 : (v == 1)));
          if (p == 0 && v == 3 && k == 0) compare1 = 16'd0;
        end
      end
    end
    compare1 = 16'd3;
    period(8'b0000_0000);
    pwm_en = 1'b0;
    tick(16'd0);
    chk("enwrap_state", 16'(state_o), 16'(0));
    chk("enwrap_pulse", 16'(cycle_pulse), 16'(0));
    chk("enwrap_pwm", 16'(pwm_out), 16'(0));
    pwm_en = 1'b1;
    tick(16'd3);
    chk("rearm_state", 16'(state_o), 16'(1));
    chk("rearm_pwm", 16'(pwm_out), 16'(0));
    tick(16'd0);
    chk("rerun_pwm", 16'(pwm_out), 16'(1));
    tick(16'd1);
    chk("rerun_pwm1", 16'(pwm_out), 16'(1));
    pwm_en = 1'b0;
    tick(16'd2);
    chk("dis_pwm", 16'(pwm_out), 16'(0));
    chk("dis_state", 16'(state_o), 16'(0));
    pwm_en = 1'b1;
    tick(16'd5);
    tick(16'd0);
    tick(16'd1);
    chk("pre_rst_pwm", 16'(pwm_out), 16'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_pwm", 16'(pwm_out), 16'(0));
    chk("async_state", 16'(state_o), 16'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    tick(16'd5);
    chk("post_rst_state", 16'(state_o), 16'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 clk  input  1  peripheral clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, asynchronous and active-high.
REQ-003 pwm_en  input  1  channel enable from the register file.
REQ-004 count_val  input  16  live value from the upstream timebase counter, sampled every clk.
REQ-005 compare1  input  16  first compare threshold (register-file value, unbuffered).
REQ-006 compare2  input  16  second compare threshold, used in unaligned mode only.
REQ-007 functions  input  2  mode: 00 left-aligned, 01 right-aligned, 1x unaligned.
REQ-008 pwm_out  output  1  registered PWM waveform.
REQ-009 cycle_pulse  output  1  registered one-clk pulse at each detected timebase wrap while running.
REQ-010 state_o  output  2  current FSM state, for debug and verification.

Function
REQ-011 The block SHALL implement FSM states IDLE=00, ARMED=01, RUN=10.
REQ-012 IDLE->ARMED SHALL occur when pwm_en=1.
REQ-013 ARMED->RUN SHALL occur when count_val==0, and SHALL load the shadow registers in the same edge.
REQ-014 RUN->IDLE and ARMED->IDLE SHALL occur on the first clk with pwm_en=0.
REQ-015 The block SHALL keep shadow registers cmp1_sh, cmp2_sh and func_sh (16/16/2 bits), loaded from compare1/compare2/functions only on the ARMED->RUN transition and on each wrap in RUN.
REQ-016 In IDLE, the shadow registers SHALL track compare1/compare2/functions every clk.
REQ-017 A wrap SHALL be defined as count_val==0 while count_val_q!=0, where count_val_q is count_val registered one clk earlier.
REQ-018 Wrap detection SHALL be edge-based, so a prescaled counter holding 0 for several clks yields exactly one wrap.
REQ-019 Left-aligned mode SHALL give pwm_next = (count_val < cmp1_sh).
REQ-020 Right-aligned mode SHALL give pwm_next = (count_val >= cmp1_sh).
REQ-021 Unaligned mode SHALL give pwm_next = (count_val >= cmp1_sh) && (count_val < cmp2_sh).
REQ-022 All compares SHALL be unsigned 16-bit with no truncation.
REQ-023 Compare boundaries SHALL be: cmp1_sh=0 gives left always 0 and right always 1; cmp1_sh=0xFFFF gives left 1 except at count 0xFFFF.
REQ-024 In unaligned mode, cmp2_sh<=cmp1_sh SHALL give constant 0.
REQ-025 In RUN, the compare SHALL use the shadow values that are current in that cycle.
REQ-026 On the wrap edge, the compare SHALL use the newly loaded values, so the new duty applies from count 0.
REQ-027 pwm_out SHALL be registered, with 1 clk latency from count_val to pwm_out.
REQ-028 pwm_out SHALL be 0 whenever the state is not RUN.
REQ-029 The first RUN-derived pwm_out SHALL appear 1 clk after entering RUN.
REQ-030 cycle_pulse SHALL be 1 for exactly one clk, registered, following each wrap detected in RUN; it SHALL be 0 in IDLE and ARMED.
REQ-031 Writes to compare1/compare2/functions in RUN SHALL have no effect on pwm_out until the next wrap.
REQ-032 With the counter period set to 0 (count_val constant 0), there SHALL be no wrap, the shadows SHALL stay frozen, and pwm_out SHALL hold its RUN value.
REQ-033 If pwm_en falls on a wrap edge, IDLE SHALL take priority and cycle_pulse SHALL not assert.
REQ-034 Re-enabling SHALL always pass through ARMED, giving glitch-free start at count 0.

Reset
REQ-035 Asserting rst SHALL immediately force state=IDLE, pwm_out=0, cycle_pulse=0, count_val_q=0 and all shadows=0, independent of clk.
REQ-036 After rst deasserts, the FSM SHALL resume at IDLE on the next clk; a reset mid-RUN SHALL drop pwm_out to 0 at once.

Structure
REQ-037 The mode encodings (00/01/1x) and the FSM state encodings SHALL be localparams in the shared timer package, which the register file also uses.
REQ-038 The block SHALL be one module with no sub-modules; the compare logic SHALL be a single combinational function feeding the pwm_out flop.

Verification
REQ-039 Left mode, cmp1=3, count 0..7 repeating, pwm_en=1 -> after ARMED->RUN at count 0, pwm_out=1 for counts 0..2 and 0 for 3..7, delayed 1 clk.
REQ-040 Right mode, cmp1=0 -> pwm_out constant 1 in RUN; left mode, cmp1=0 -> constant 0.
REQ-041 Unaligned mode, cmp1=2, cmp2=5, count 0..7 -> high on counts 2..4 only; then cmp2=1 -> constant 0 after the next wrap.
REQ-042 In RUN, left mode, cmp1=3, change compare1 to 6 at count 4 -> duty unchanged until count wraps to 0, then high for counts 0..5; cycle_pulse one clk per wrap.
REQ-043 Counter prescaled (each value held 4 clks), period 3 -> exactly one cycle_pulse per wrap and no double shadow load.
REQ-044 Assert rst during RUN with pwm_out=1 -> pwm_out=0 and state_o=00 without a clk edge; pwm_en=0 mid-period -> pwm_out=0 the next clk.
